// File: rtl/tiny_dnn_pkg.sv
// rtl/tiny_dnn_pkg.sv - shared types and constants for the DNN layer sequencer
package tiny_dnn_pkg;

  localparam int          N_LAYERS_MAX = 8;
  localparam logic [15:0] TIMEOUT_MAX  = 16'hFFFF;

  typedef struct packed {
    logic       backprop;
    logic [3:0] dd;
    logic [3:0] id;
    logic [9:0] is;
    logic [4:0] ih;
    logic [4:0] iw;
    logic [3:0] od;
    logic [9:0] os;
    logic [4:0] oh;
    logic [4:0] ow;
    logic [9:0] fs;
    logic [9:0] ks;
    logic [4:0] kh;
    logic [4:0] kw;
  } layer_cfg_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/tiny_dnn_layer_tbl.sv
// rtl/tiny_dnn_layer_tbl.sv - 8-entry layer table, one write port, one combinational read port
module tiny_dnn_layer_tbl
  import tiny_dnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  layer_cfg_t wdata,
  input  logic [2:0] raddr,
  output layer_cfg_t rdata
);

  layer_cfg_t mem [N_LAYERS_MAX];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_LAYERS_MAX; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tiny_dnn_layer_seq.sv
// rtl/tiny_dnn_layer_seq.sv - layer sequencer; TINY_DNN_LAYER_SEQ_TIMEOUT_EN adds a RUN watchdog
module tiny_dnn_layer_seq
  import tiny_dnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  layer_cfg_t cfg_data,
  input  logic [2:0] n_layers,
  input  logic       start,
  input  logic       abort,
  input  logic       s_fin,
  output logic       s_init,
  output logic       backprop,
  output logic [3:0] dd,
  output logic [3:0] id,
  output logic [3:0] od,
  output logic [9:0] is,
  output logic [9:0] os,
  output logic [9:0] fs,
  output logic [9:0] ks,
  output logic [4:0] ih,
  output logic [4:0] iw,
  output logic [4:0] oh,
  output logic [4:0] ow,
  output logic [4:0] kh,
  output logic [4:0] kw,
  output logic       bank,
  output logic [2:0] layer_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state;
  layer_cfg_t cur;
  layer_cfg_t rd_data;
  logic [2:0] n_lat;
  logic       tbl_we;
`ifdef TINY_DNN_LAYER_SEQ_TIMEOUT_EN
  logic [15:0] wdog;
`endif

  // The table is frozen while a sequence runs so the active entry cannot change under it.
  assign tbl_we = cfg_we && !busy;

  tiny_dnn_layer_tbl u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (layer_idx),
    .rdata (rd_data)
  );

  assign {backprop, dd, id, is, ih, iw, od, os, oh, ow, fs, ks, kh, kw} = cur;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      n_lat     <= '0;
      layer_idx <= '0;
      bank      <= 1'b0;
      busy      <= 1'b0;
      s_init    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef TINY_DNN_LAYER_SEQ_TIMEOUT_EN
      wdog      <= '0;
`endif
    end else begin
      s_init <= 1'b0;
      done   <= 1'b0;
      if (cfg_we && busy) err <= 1'b1;

      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              n_lat     <= n_layers;
              layer_idx <= '0;
              bank      <= 1'b0;
              err       <= 1'b0;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
          LOAD: begin
            cur    <= rd_data;
            s_init <= 1'b1;
            state  <= INIT;
          end
          INIT: begin
`ifdef TINY_DNN_LAYER_SEQ_TIMEOUT_EN
            wdog  <= '0;
`endif
            state <= RUN;
          end
          RUN: begin
            if (s_fin) begin
              if (layer_idx == n_lat) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                layer_idx <= layer_idx + 3'd1;
                bank      <= ~bank;
                state     <= LOAD;
              end
`ifdef TINY_DNN_LAYER_SEQ_TIMEOUT_EN
            end else if (wdog == TIMEOUT_MAX - 16'd1) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              wdog <= wdog + 16'd1;
`endif
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tiny_dnn_layer_seq.sv
// tb/tb_tiny_dnn_layer_seq.sv - directed bench for tiny_dnn_layer_seq
module tb_tiny_dnn_layer_seq;
  import tiny_dnn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  layer_cfg_t cfg_data = '0;
  logic [2:0] n_layers = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_fin = 1'b0;
  logic       s_init, backprop, bank, busy, done, err;
  logic [3:0] dd, id, od;
  logic [9:0] is, os, fs, ks;
  logic [4:0] ih, iw, oh, ow, kh, kw;
  logic [2:0] layer_idx;
  layer_cfg_t obs_cfg;
  layer_cfg_t exp_tbl [3];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  tiny_dnn_layer_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .n_layers(n_layers), .start(start), .abort(abort), .s_fin(s_fin), .s_init(s_init),
    .backprop(backprop), .dd(dd), .id(id), .od(od), .is(is), .os(os), .fs(fs), .ks(ks),
    .ih(ih), .iw(iw), .oh(oh), .ow(ow), .kh(kh), .kw(kw), .bank(bank),
    .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
  );

  assign obs_cfg = {backprop, dd, id, is, ih, iw, od, os, oh, ow, fs, ks, kh, kw};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [82:0] obs, input logic [82:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    layer_cfg_t e0, e1, e2, junk;
    int fin_at, last_fin, n_init, n_done, c0;

    e0 = '0; e0.dd = 4'd2; e0.id = 4'd3; e0.kh = 5'd2; e0.kw = 5'd2;
    e1 = '0; e1.backprop = 1'b1; e1.dd = 4'h5; e1.is = 10'h155; e1.oh = 5'd17;
    e1.fs = 10'h3ff; e1.ks = 10'd9; e1.kw = 5'd3;
    e2 = '0; e2.od = 4'hf; e2.os = 10'h2aa; e2.ih = 5'd31; e2.iw = 5'd1;
    e2.ow = 5'd30; e2.kh = 5'd7;
    junk = '1;
    exp_tbl[0] = e0; exp_tbl[1] = e1; exp_tbl[2] = e2;

    tick; tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sinit", s_init, 0);
    chk("rst_idx", layer_idx, 0);
    chk("rst_bank", bank, 0);
    chk("rst_cfg", obs_cfg, 0);
    rst = 1'b1;

    cfg_we = 1'b1;
    cfg_addr = 3'd0; cfg_data = e0; tick;
    cfg_addr = 3'd1; cfg_data = e1; tick;
    cfg_addr = 3'd2; cfg_data = e2; tick;
    cfg_we = 1'b0;

    // single layer, start at cycle 10
    while (cyc < 10) tick;
    n_layers = 3'd0; start = 1'b1; tick; start = 1'b0;
    chk("one_load_busy", busy, 1);
    chk("one_load_sinit", s_init, 0);
    tick;
    chk("one_sinit_c12", s_init, 1);
    chk("one_cfg", obs_cfg, e0);
    chk("one_idx", layer_idx, 0);
    chk("one_bank", bank, 0);
    tick;
    chk("one_sinit_width", s_init, 0);
    while (cyc < 40) tick;
    s_fin = 1'b1; tick; s_fin = 1'b0;
    chk("one_done_c41", done, 1);
    chk("one_busy_c41", busy, 1);
    tick;
    chk("one_busy_c42", busy, 0);
    chk("one_done_c42", done, 0);

    // three layers
    n_layers = 3'd2; start = 1'b1; tick; start = 1'b0;
    n_init = 0; n_done = 0; fin_at = -1; last_fin = -1;
    for (int i = 0; i < 200 && busy; i++) begin
      s_fin = 1'b0;
      if (s_init) begin
        if (n_init < 3) begin
          chk($sformatf("l3_idx%0d", n_init), layer_idx, n_init);
          chk($sformatf("l3_bank%0d", n_init), bank, n_init % 2);
          chk($sformatf("l3_cfg%0d", n_init), obs_cfg, exp_tbl[n_init]);
        end
        if (n_init > 0) chk($sformatf("l3_lat%0d", n_init), cyc - last_fin, 2);
        fin_at = cyc + 20;
        n_init++;
      end
      if (done) n_done++;
      if (cyc == fin_at) begin
        s_fin = 1'b1;
        last_fin = cyc;
      end
      tick;
    end
    s_fin = 1'b0;
    chk("l3_n_init", n_init, 3);
    chk("l3_n_done", n_done, 1);
    chk("l3_idle", busy, 0);

    // abort during RUN of layer 1
    start = 1'b1; tick; start = 1'b0;
    fin_at = -1;
    for (int i = 0; i < 100; i++) begin
      s_fin = 1'b0;
      if (s_init && layer_idx == 3'd1) break;
      if (s_init) fin_at = cyc + 5;
      if (cyc == fin_at) s_fin = 1'b1;
      tick;
    end
    s_fin = 1'b0;
    chk("ab_reach_l1", s_init, 1);
    tick; tick;
    abort = 1'b1; tick; abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_idx", layer_idx, 1);
    chk("ab_bank", bank, 1);
    chk("ab_cfg_hold", obs_cfg, e1);
    n_init = 0; n_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n_done++;
      if (s_init) n_init++;
      tick;
    end
    chk("ab_no_done", n_done, 0);
    chk("ab_no_sinit", n_init, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("ab_restart_busy", busy, 1);
    tick;
    chk("ab_restart_sinit", s_init, 1);
    chk("ab_restart_idx", layer_idx, 0);
    chk("ab_restart_bank", bank, 0);
    chk("ab_restart_cfg", obs_cfg, e0);
    tick;

    // illegal write while busy, then s_fin in IDLE
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = junk; tick; cfg_we = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk("ill_abort_idle", busy, 0);
    chk("ill_err_sticky", err, 1);
    s_fin = 1'b1; tick; s_fin = 1'b0;
    chk("idle_fin_busy", busy, 0);
    chk("idle_fin_done", done, 0);
    tick;
    chk("idle_fin_busy2", busy, 0);
    chk("idle_fin_sinit", s_init, 0);
    n_layers = 3'd0; start = 1'b1; tick; start = 1'b0;
    chk("ill_err_clear", err, 0);
    tick;
    chk("ill_tbl_unchanged", obs_cfg, e0);
    tick;

    // abort and s_fin together
    abort = 1'b1; s_fin = 1'b1; tick; abort = 1'b0; s_fin = 1'b0;
    chk("sim_idle", busy, 0);
    chk("sim_no_done", done, 0);
    tick;
    chk("sim_no_done2", done, 0);
    chk("sim_no_sinit", s_init, 0);

    // reset mid-RUN
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = junk; tick; cfg_we = 1'b0;
    chk("mr_err_before", err, 1);
    rst = 1'b0; start = 1'b1; s_fin = 1'b1; cfg_we = 1'b1; tick;
    rst = 1'b1; start = 1'b0; s_fin = 1'b0; cfg_we = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_err", err, 0);
    chk("mr_done", done, 0);
    chk("mr_sinit", s_init, 0);
    chk("mr_idx", layer_idx, 0);
    chk("mr_cfg", obs_cfg, 0);
    start = 1'b1; tick; start = 1'b0;
    tick;
    chk("mr_sinit_after", s_init, 1);
    chk("mr_tbl_zero", obs_cfg, 0);
    tick;

    // watchdog
`ifdef TINY_DNN_LAYER_SEQ_TIMEOUT_EN
    c0 = cyc - 1;
    n_done = 0;
    while (busy && cyc < c0 + 70000) begin
      if (done) n_done++;
      tick;
    end
    chk("wd_cycle", cyc - c0, 65536);
    chk("wd_err", err, 1);
    chk("wd_idle", busy, 0);
    chk("wd_no_done", n_done, 0);
`else
    c0 = cyc;
    while (cyc < c0 + 100) tick;
    chk("nowd_busy", busy, 1);
    chk("nowd_err", err, 0);
    s_fin = 1'b1; tick; s_fin = 1'b0;
    chk("nowd_done", done, 1);
    tick;
    chk("nowd_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
